// File: rtl/tele_prbs_tx.sv
// PRBS7/PRBS15 test-pattern source for the telemetry link, with a programmable
// bit period and single-bit error injection.
module tele_prbs_tx #(
  parameter int DIV_W     = 16,
  parameter int INJ_CNT_W = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 i_enable,
  input  logic                 i_sel,
  input  logic [DIV_W-1:0]     i_div,
  input  logic                 i_inj_req,
  output logic                 o_tx,
  output logic                 o_bit_stb,
  output logic                 o_inj_ack,
  output logic [INJ_CNT_W-1:0] o_inj_cnt,
  output logic                 o_update
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2
  } state_t;

  // FSM state is kept under this plain name so checkers can bind to it.
  state_t           state;
  logic [14:0]      lfsr;
  logic [DIV_W-1:0] cnt;
  logic             pend;
  logic             sel_q;

  logic fb;
  logic locked;
  logic inj;

  // Polynomial follows sel_q, the selection captured at the last seed.
  always_comb begin
    fb     = sel_q ? (lfsr[14] ^ lfsr[13]) : (lfsr[6] ^ lfsr[5]);
    locked = sel_q ? (lfsr == 15'd0) : (lfsr[6:0] == 7'd0);
    inj    = pend | i_inj_req;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      lfsr      <= 15'h7FFF;
      cnt       <= '0;
      pend      <= 1'b0;
      sel_q     <= 1'b0;
      o_tx      <= 1'b1;
      o_bit_stb <= 1'b0;
      o_inj_ack <= 1'b0;
      o_inj_cnt <= '0;
      o_update  <= 1'b0;
    end else begin
      o_bit_stb <= 1'b0;
      o_inj_ack <= 1'b0;
      o_update  <= 1'b0;
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          cnt  <= '0;
          pend <= 1'b0;
          if (i_enable) state <= SEED;
        end
        SEED: begin
          lfsr      <= 15'h7FFF;
          cnt       <= '0;
          pend      <= 1'b0;
          sel_q     <= i_sel;
          o_inj_cnt <= '0;
          o_update  <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (!i_enable) begin
            // Disable takes priority over a strobe falling in the same cycle.
            state <= IDLE;
            o_tx  <= 1'b1;
            cnt   <= '0;
            pend  <= 1'b0;
          end else if (i_sel != sel_q) begin
            state <= SEED;
          end else if (cnt >= i_div) begin
            cnt       <= '0;
            o_bit_stb <= 1'b1;
            o_tx      <= fb ^ inj;
            if (locked)     lfsr      <= 15'h7FFF;
            else if (sel_q) lfsr      <= {lfsr[13:0], fb};
            else            lfsr[6:0] <= {lfsr[5:0], fb};
            if (inj) begin
              pend      <= 1'b0;
              o_inj_ack <= 1'b1;
              if (o_inj_cnt != {INJ_CNT_W{1'b1}}) o_inj_cnt <= o_inj_cnt + 1'b1;
            end
          end else begin
            cnt  <= cnt + 1'b1;
            pend <= pend | i_inj_req;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tele_prbs_tx.sv
// Directed bench for tele_prbs_tx: stream content, bit timing, injection,
// reseed, disable and asynchronous reset behaviour.
module tb_tele_prbs_tx;

  localparam int DIV_W     = 16;
  localparam int INJ_CNT_W = 16;

  logic                 Clock;
  logic                 Reset;
  logic                 i_enable;
  logic                 i_sel;
  logic [DIV_W-1:0]     i_div;
  logic                 i_inj_req;
  logic                 o_tx;
  logic                 o_bit_stb;
  logic                 o_inj_ack;
  logic [INJ_CNT_W-1:0] o_inj_cnt;
  logic                 o_update;

  tele_prbs_tx #(.DIV_W(DIV_W), .INJ_CNT_W(INJ_CNT_W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .i_enable  (i_enable),
    .i_sel     (i_sel),
    .i_div     (i_div),
    .i_inj_req (i_inj_req),
    .o_tx      (o_tx),
    .o_bit_stb (o_bit_stb),
    .o_inj_ack (o_inj_ack),
    .o_inj_cnt (o_inj_cnt),
    .o_update  (o_update)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks    = 0;
  int failures  = 0;
  int stray_ack = 0;
  int upd_seen  = 0;

  logic [14:0] mreg;
  logic        b7  [254];
  logic        b15 [32782];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Golden stream model, x^7+x^6+1 or x^15+x^14+1 from the all-ones seed.
  task automatic model_seed();
    mreg = 15'h7FFF;
  endtask

  task automatic model_bit(input logic sel, output logic b);
    if (sel) begin
      b    = mreg[14] ^ mreg[13];
      mreg = {mreg[13:0], b};
    end else begin
      b         = mreg[6] ^ mreg[5];
      mreg[6:0] = {mreg[5:0], b};
    end
  endtask

  // Driver tasks; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge Clock);
  endtask

  task automatic next_bit(output logic b, output logic a, output int gap);
    gap = 0;
    do begin
      step();
      gap++;
      if (o_inj_ack && !o_bit_stb) stray_ack++;
      if (o_update) upd_seen++;
    end while (!o_bit_stb && gap < 200);
    if (!o_bit_stb) begin
      failures++;
      $error("FAIL strobe_timeout observed=no_strobe expected=strobe");
    end
    b = o_tx;
    a = o_inj_ack;
  endtask

  task automatic wait_update(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_update && n < 50);
    if (!o_update) begin
      failures++;
      $error("FAIL update_timeout observed=no_update expected=update");
    end
  endtask

  task automatic restart(input logic sel, output int n);
    i_enable = 1'b0;
    step();
    step();
    i_sel    = sel;
    i_enable = 1'b1;
    wait_update(n);
  endtask

  initial begin
    logic b, a, e;
    int   g, n, mism, gap_bad, run, max_run, ones, diffs, acks, stb_cnt;
    logic [14:0] word;

    Reset     = 1'b0;
    i_enable  = 1'b0;
    i_sel     = 1'b0;
    i_div     = 16'd3;
    i_inj_req = 1'b0;
    step();
    step();
    check("rst_tx",      32'(o_tx),      32'd1);
    check("rst_stb",     32'(o_bit_stb), 32'd0);
    check("rst_ack",     32'(o_inj_ack), 32'd0);
    check("rst_inj_cnt", 32'(o_inj_cnt), 32'd0);
    check("rst_update",  32'(o_update),  32'd0);
    Reset = 1'b1;
    step();
    check("idle_tx", 32'(o_tx), 32'd1);

    // 1: PRBS7, i_div=3
    i_enable = 1'b1;
    wait_update(n);
    check("t1_update_lat", 32'(n), 32'd2);
    upd_seen = 0;
    word = '0;
    gap_bad = 0;
    for (int i = 0; i < 7; i++) begin
      next_bit(b, a, g);
      if (g != 4) gap_bad++;
      word = {word[13:0], b};
    end
    check("t1_gap4",      32'(gap_bad),  32'd0);
    check("t1_first7",    32'(word[6:0]), 32'h01);
    check("t1_upd_once",  32'(upd_seen), 32'd0);

    // 2: period checks at i_div=0
    i_div = 16'd0;
    restart(1'b0, n);
    model_seed();
    mism = 0; gap_bad = 0;
    for (int i = 0; i < 254; i++) begin
      next_bit(b, a, g);
      if (g != 1) gap_bad++;
      b7[i] = b;
      if (i < 127) begin
        model_bit(1'b0, e);
        if (b !== e) mism++;
      end
    end
    check("t2_div0_gap", 32'(gap_bad), 32'd0);
    check("t2_p7_model", 32'(mism),    32'd0);
    mism = 0; run = 0; max_run = 0; ones = 0;
    for (int i = 0; i < 127; i++) begin
      if (b7[i + 127] !== b7[i]) mism++;
      if (b7[i]) begin ones++; run = 0; end
      else begin run++; if (run > max_run) max_run = run; end
    end
    check("t2_p7_period",  32'(mism),    32'd0);
    check("t2_p7_zero_run", 32'(max_run), 32'd6);
    check("t2_p7_ones",    32'(ones),    32'd64);

    restart(1'b1, n);
    model_seed();
    mism = 0;
    for (int i = 0; i < 32782; i++) begin
      next_bit(b, a, g);
      b15[i] = b;
      if (i < 32767) begin
        model_bit(1'b1, e);
        if (b !== e) mism++;
      end
    end
    check("t2_p15_model", 32'(mism), 32'd0);
    word = '0; mism = 0; run = 0; max_run = 0; ones = 0;
    for (int i = 0; i < 15; i++) begin
      word = {word[13:0], b15[i]};
      if (b15[i + 32767] !== b15[i]) mism++;
    end
    for (int i = 0; i < 32767; i++) begin
      if (b15[i]) begin ones++; run = 0; end
      else begin run++; if (run > max_run) max_run = run; end
    end
    check("t2_p15_first15", 32'(word),    32'h0001);
    check("t2_p15_period",  32'(mism),    32'd0);
    check("t2_p15_ones",    32'(ones),    32'd16384);
    check("t2_p15_zero_run", 32'(max_run), 32'd14);

    // 3: injection at i_div=3 on PRBS7
    i_div = 16'd3;
    restart(1'b0, n);
    model_seed();
    diffs = 0; acks = 0; stray_ack = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 1) begin
        i_inj_req = 1'b1; step();
        i_inj_req = 1'b0; step();
        i_inj_req = 1'b1; step();
        i_inj_req = 1'b0;
      end else if (i == 4) begin
        step(); step(); step();
        i_inj_req = 1'b1;
      end
      next_bit(b, a, g);
      i_inj_req = 1'b0;
      model_bit(1'b0, e);
      if (b !== e) diffs++;
      if (a) acks++;
      if (i == 1) check("t3_merged_inv", 32'(b ^ e), 32'd1);
      if (i == 4) check("t3_coinc_inv",  32'(b ^ e), 32'd1);
    end
    check("t3_diffs",     32'(diffs),     32'd2);
    check("t3_acks",      32'(acks),      32'd2);
    check("t3_stray_ack", 32'(stray_ack), 32'd0);
    check("t3_inj_cnt",   32'(o_inj_cnt), 32'd2);

    // 4: i_sel toggle in RUN with an injection pending
    i_inj_req = 1'b1; step();
    i_inj_req = 1'b0;
    i_sel = 1'b1;
    step();
    wait_update(n);
    check("t4_seed_lat", 32'(n),         32'd1);
    check("t4_inj_cnt0", 32'(o_inj_cnt), 32'd0);
    word = '0; acks = 0;
    for (int i = 0; i < 15; i++) begin
      next_bit(b, a, g);
      if (i == 0) check("t4_first_gap", 32'(g), 32'd4);
      word = {word[13:0], b};
      if (a) acks++;
    end
    check("t4_first15",  32'(word), 32'h0001);
    check("t4_no_ack",   32'(acks), 32'd0);

    // 5: disable mid-period, request while idle, re-enable
    next_bit(b, a, g);
    check("t5_bit15", 32'(b), 32'd0);
    step();
    i_enable = 1'b0;
    step();
    check("t5_idle_tx", 32'(o_tx), 32'd1);
    i_inj_req = 1'b1;
    stb_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_bit_stb || !o_tx) stb_cnt++;
    end
    check("t5_idle_quiet", 32'(stb_cnt), 32'd0);
    i_inj_req = 1'b0;
    i_enable = 1'b1;
    wait_update(n);
    check("t5_reseed_lat", 32'(n), 32'd2);
    word = '0; acks = 0;
    for (int i = 0; i < 15; i++) begin
      next_bit(b, a, g);
      word = {word[13:0], b};
      if (a) acks++;
    end
    check("t5_restart15", 32'(word),      32'h0001);
    check("t5_no_ack",    32'(acks),      32'd0);
    check("t5_inj_cnt0",  32'(o_inj_cnt), 32'd0);
    i_inj_req = 1'b1;
    next_bit(b, a, g);
    i_inj_req = 1'b0;
    check("t5_inj_bit",  32'(b),         32'd1);
    check("t5_inj_ack",  32'(a),         32'd1);
    check("t5_inj_cnt1", 32'(o_inj_cnt), 32'd1);
    next_bit(b, a, g);
    check("t5_bit16", 32'(b), 32'd0);

    // 6: asynchronous reset between edges, then live i_div reduction
    step();
    #2;
    Reset = 1'b0;
    #1;
    check("t6_async_tx",      32'(o_tx),      32'd1);
    check("t6_async_inj_cnt", 32'(o_inj_cnt), 32'd0);
    check("t6_async_stb",     32'(o_bit_stb), 32'd0);
    check("t6_async_upd",     32'(o_update),  32'd0);
    i_sel = 1'b0;
    i_div = 16'd9;
    step();
    Reset = 1'b1;
    wait_update(n);
    check("t6_update_lat", 32'(n), 32'd2);
    for (int i = 0; i < 5; i++) step();
    i_div = 16'd2;
    next_bit(b, a, g);
    check("t6_gap_first", 32'(g), 32'd1);
    check("t6_bit0",      32'(b), 32'd0);
    next_bit(b, a, g);
    check("t6_gap_2", 32'(g), 32'd3);
    next_bit(b, a, g);
    check("t6_gap_3", 32'(g), 32'd3);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
